// File: rtl/ldm_stm_sequencer.sv
// -----------------------------------------------------------------------------
// ldm_stm_sequencer
//
// Multi-cycle sequencer for ARM load/store-multiple instructions. When the
// decoder flags an LDM/STM in ID (start), this block latches the instruction
// and the base register value. It then walks the 16-bit register list and
// issues one word transfer per cycle between data RAM and the register file.
// For the whole sequence it holds the front end via stall. When W=1 it
// finishes with a base-register writeback.
//
// Sequence: IDLE -> CALC -> XFER x n -> [WB] -> FIN -> IDLE
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-low reset
//   start      decoded LDM/STM valid in ID this cycle
//   instr      P=[24] U=[23] W=[21] L=[20] Rn=[19:16] list=[15:0]
//   base_val   value of Rn, sampled together with start
//   rf_rdata   same-cycle RF read data for rf_raddr (STM source)
//   mem_rdata  same-cycle RAM read data for mem_addr (LDM source)
//   stall      hold PC/IF-ID and select the ID NOP mux
//   busy       sequencer is not idle
//   mem_en     memory access valid this cycle
//   mem_rw     1 = store (write), 0 = load (read)
//   mem_size   always word (2'b00)
//   mem_addr   access address
//   mem_wdata  store data (rf_rdata during an STM transfer, else 0)
//   rf_raddr   register being stored
//   rf_we      RF write enable (load data or base writeback)
//   rf_waddr   RF write register
//   rf_wdata   RF write data
//   done       one-cycle pulse when the sequence completes
// -----------------------------------------------------------------------------
module ldm_stm_sequencer #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int WORD_BYTES = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [31:0]       instr,
    input  logic [ADDR_W-1:0] base_val,
    input  logic [DATA_W-1:0] rf_rdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall,
    output logic              busy,
    output logic              mem_en,
    output logic              mem_rw,
    output logic [1:0]        mem_size,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [3:0]        rf_raddr,
    output logic              rf_we,
    output logic [3:0]        rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CALC,
        S_XFER,
        S_WB,
        S_FIN
    } state_t;

    state_t            r_state;
    logic              r_p;
    logic              r_u;
    logic              r_w;
    logic              r_l;
    logic [3:0]        r_rn;
    logic [15:0]       r_list;      // registers still to transfer
    logic [ADDR_W-1:0] r_base;
    logic [ADDR_W-1:0] r_cur;       // address of the next transfer
    logic [ADDR_W-1:0] r_wb_val;
    logic              r_do_wb;

    logic [4:0]        w_n;
    logic [ADDR_W-1:0] w_span;
    logic [ADDR_W-1:0] w_stride;
    logic [ADDR_W-1:0] w_start_addr;
    logic [3:0]        w_reg;
    logic [15:0]       w_list_next;
    logic              w_unused_instr;

    // Condition code, opcode and S bit do not affect the sequence.
    assign w_unused_instr = ^{instr[31:25], instr[22]};

    function automatic logic [4:0] popcount16(input logic [15:0] v);
        logic [4:0] cnt;
        cnt = '0;
        for (int i = 0; i < 16; i++) begin
            cnt = cnt + 5'(v[i]);
        end
        return cnt;
    endfunction

    assign w_n      = popcount16(r_list);
    assign w_stride = ADDR_W'(WORD_BYTES);
    assign w_span   = ADDR_W'(w_n) * w_stride;

    // The lowest-numbered register always goes to the lowest address. Every
    // mode therefore walks upward from a mode-dependent start address.
    always_comb begin
        w_start_addr = r_base;
        case ({r_p, r_u})
            2'b01:   w_start_addr = r_base;                      // IA
            2'b11:   w_start_addr = r_base + w_stride;           // IB
            2'b00:   w_start_addr = r_base - w_span + w_stride;  // DA
            default: w_start_addr = r_base - w_span;             // DB
        endcase
    end

    // Lowest set bit of the remaining list. The loop runs downward, so the
    // final assignment is the lowest index.
    always_comb begin
        // NOTE: a default before any conditional assignment keeps this purely
        // combinational; a path that left w_reg unassigned would infer a latch.
        w_reg = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (r_list[i]) begin
                w_reg = 4'(i);
            end
        end
    end

    // Clearing the lowest set bit: v & (v - 1).
    assign w_list_next = r_list & (r_list - 16'd1);

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments, so every
        // register in this block samples pre-edge values regardless of order.
        if (!reset) begin
            r_state  <= S_IDLE;
            r_p      <= 1'b0;
            r_u      <= 1'b0;
            r_w      <= 1'b0;
            r_l      <= 1'b0;
            r_rn     <= 4'd0;
            r_list   <= 16'd0;
            r_base   <= '0;
            r_cur    <= '0;
            r_wb_val <= '0;
            r_do_wb  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_p     <= instr[24];
                        r_u     <= instr[23];
                        r_w     <= instr[21];
                        r_l     <= instr[20];
                        r_rn    <= instr[19:16];
                        r_list  <= instr[15:0];
                        r_base  <= base_val;
                        r_state <= S_CALC;
                    end
                end
                S_CALC: begin
                    r_cur    <= w_start_addr;
                    r_wb_val <= r_u ? (r_base + w_span) : (r_base - w_span);
                    // If a load overwrites the base register, the loaded value
                    // wins. An empty list leaves the base untouched.
                    r_do_wb  <= r_w && (r_list != 16'd0) && !(r_l && r_list[r_rn]);
                    r_state  <= (r_list == 16'd0) ? S_FIN : S_XFER;
                end
                S_XFER: begin
                    r_list <= w_list_next;
                    r_cur  <= r_cur + w_stride;
                    if (w_list_next == 16'd0) begin
                        r_state <= r_do_wb ? S_WB : S_FIN;
                    end
                end
                S_WB:    r_state <= S_FIN;
                S_FIN:   r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Outputs decode only the registered state. The exceptions are stall in
    // IDLE, which must stop the front end in the same cycle as start, and the
    // same-cycle RAM/RF read data passed through during XFER.
    assign busy     = (r_state != S_IDLE);
    assign mem_size = 2'b00;

    always_comb begin
        stall     = 1'b0;
        mem_en    = 1'b0;
        mem_rw    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        rf_raddr  = 4'd0;
        rf_we     = 1'b0;
        rf_waddr  = 4'd0;
        rf_wdata  = '0;
        done      = 1'b0;
        case (r_state)
            S_IDLE: stall = start;
            S_CALC: stall = 1'b1;
            S_XFER: begin
                stall    = 1'b1;
                mem_en   = 1'b1;
                mem_rw   = !r_l;
                mem_addr = r_cur;
                if (r_l) begin
                    rf_we    = 1'b1;
                    rf_waddr = w_reg;
                    rf_wdata = mem_rdata;
                end else begin
                    rf_raddr  = w_reg;
                    mem_wdata = rf_rdata;
                end
            end
            S_WB: begin
                stall    = 1'b1;
                rf_we    = 1'b1;
                rf_waddr = r_rn;
                rf_wdata = DATA_W'(r_wb_val);
            end
            S_FIN:   done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// -----------------------------------------------------------------------------
// tb_ldm_stm_sequencer
//
// Directed bench for ldm_stm_sequencer. A small RAM and register file supply
// same-cycle read data. A negedge monitor logs every memory access and RF
// write, along with the stall and done timing, relative to the start cycle
// (cycle 0). Each test compares those logs with hand-computed values.
// -----------------------------------------------------------------------------
module tb_ldm_stm_sequencer;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] instr;
    logic [31:0] base_val;
    logic [31:0] rf_rdata;
    logic [31:0] mem_rdata;
    logic        stall;
    logic        busy;
    logic        mem_en;
    logic        mem_rw;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  rf_raddr;
    logic        rf_we;
    logic [3:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        done;

    ldm_stm_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .instr     (instr),
        .base_val  (base_val),
        .rf_rdata  (rf_rdata),
        .mem_rdata (mem_rdata),
        .stall     (stall),
        .busy      (busy),
        .mem_en    (mem_en),
        .mem_rw    (mem_rw),
        .mem_size  (mem_size),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .rf_raddr  (rf_raddr),
        .rf_we     (rf_we),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] tb_mem [0:255];
    logic [31:0] tb_rf  [0:15];

    assign mem_rdata = tb_mem[mem_addr[9:2]];
    assign rf_rdata  = tb_rf[rf_raddr];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Monitor logs
    logic        mon;
    int          cyc;
    int          stall_cnt;
    int          stall_last;
    int          done_cyc;
    logic [31:0] q_mem_addr  [$];
    logic [31:0] q_mem_wdata [$];
    bit          q_mem_rw    [$];
    logic [3:0]  q_rf_waddr  [$];
    logic [31:0] q_rf_wdata  [$];

    always @(negedge clk) begin
        if (mon) begin
            if (stall) begin
                stall_cnt++;
                stall_last = cyc;
            end
            if (done && done_cyc < 0) done_cyc = cyc;
            if (mem_en) begin
                q_mem_addr.push_back(mem_addr);
                q_mem_wdata.push_back(mem_wdata);
                q_mem_rw.push_back(mem_rw);
            end
            if (rf_we) begin
                q_rf_waddr.push_back(rf_waddr);
                q_rf_wdata.push_back(rf_wdata);
            end
            cyc++;
        end
    end

    task automatic clear_logs();
        cyc        = 0;
        stall_cnt  = 0;
        stall_last = -1;
        done_cyc   = -1;
        q_mem_addr.delete();
        q_mem_wdata.delete();
        q_mem_rw.delete();
        q_rf_waddr.delete();
        q_rf_wdata.delete();
    endtask

    // Pulse start for one cycle, then wait (bounded) for done.
    task automatic run_seq(input logic [31:0] ins, input logic [31:0] base);
        clear_logs();
        @(posedge clk); #1;
        instr    = ins;
        base_val = base;
        start    = 1'b1;
        mon      = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 40 && done_cyc < 0; k++) @(posedge clk);
        #1;
        mon = 1'b0;
        @(negedge clk);
        check("idle_after_fin", 32'(busy), 32'd0);
    endtask

    task automatic exp_mem(input string tag, input int i, input logic [31:0] a,
                           input logic [31:0] d, input logic rw);
        if (i < q_mem_addr.size()) begin
            check({tag, "_addr"},  q_mem_addr[i],      a);
            check({tag, "_wdata"}, q_mem_wdata[i],     d);
            check({tag, "_rw"},    32'(q_mem_rw[i]),   32'(rw));
        end else begin
            check({tag, "_present"}, q_mem_addr.size(), i + 1);
        end
    endtask

    task automatic exp_rf(input string tag, input int i, input logic [3:0] r, input logic [31:0] d);
        if (i < q_rf_waddr.size()) begin
            check({tag, "_reg"},  32'(q_rf_waddr[i]), 32'(r));
            check({tag, "_data"}, q_rf_wdata[i],      d);
        end else begin
            check({tag, "_present"}, q_rf_waddr.size(), i + 1);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) tb_mem[i] = 32'hDEAD_0000 | 32'(i);
        for (int i = 0; i < 16; i++)  tb_rf[i]  = 32'hBEEF_0000 | 32'(i);
        tb_mem[8'h40] = 32'h0000_000A;   // 0x100
        tb_mem[8'h41] = 32'h0000_000B;   // 0x104
        tb_mem[8'h42] = 32'h0000_000C;   // 0x108
        tb_mem[8'h11] = 32'h1234_5678;   // 0x44
        tb_mem[8'h07] = 32'h0000_1C1C;   // 0x1C
        tb_mem[8'h08] = 32'h0000_2020;   // 0x20
        tb_mem[8'h20] = 32'h8080_0001;   // 0x80
        tb_mem[8'h21] = 32'h8484_0005;   // 0x84
        tb_rf[4]  = 32'h4444_4444;
        tb_rf[14] = 32'hEEEE_0000;
        tb_rf[8]  = 32'h0808_0808;
        tb_rf[9]  = 32'h0909_0909;
        tb_rf[10] = 32'h0A0A_0A0A;
        tb_rf[11] = 32'h0B0B_0B0B;

        mon      = 1'b0;
        start    = 1'b0;
        instr    = 32'd0;
        base_val = 32'd0;
        reset    = 1'b0;
        clear_logs();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy",     32'(busy),     32'd0);
        check("rst_stall",    32'(stall),    32'd0);
        check("rst_mem_en",   32'(mem_en),   32'd0);
        check("rst_rf_we",    32'(rf_we),    32'd0);
        check("rst_done",     32'(done),     32'd0);
        check("rst_mem_size", 32'(mem_size), 32'd0);
        check("rst_mem_addr", mem_addr,      32'd0);
        @(posedge clk); #1;
        reset = 1'b1;

        // 1: LDMIA R0!,{R1-R3}, R0=0x100
        run_seq(32'hE8B0_000E, 32'h0000_0100);
        check("t1_mem_cnt", q_mem_addr.size(), 3);
        exp_mem("t1_m0", 0, 32'h100, 32'd0, 1'b0);
        exp_mem("t1_m1", 1, 32'h104, 32'd0, 1'b0);
        exp_mem("t1_m2", 2, 32'h108, 32'd0, 1'b0);
        check("t1_rf_cnt", q_rf_waddr.size(), 4);
        exp_rf("t1_r1", 0, 4'd1, 32'h0A);
        exp_rf("t1_r2", 1, 4'd2, 32'h0B);
        exp_rf("t1_r3", 2, 4'd3, 32'h0C);
        exp_rf("t1_wb", 3, 4'd0, 32'h10C);
        check("t1_done_cyc",   done_cyc,   6);
        check("t1_stall_cnt",  stall_cnt,  6);
        check("t1_stall_last", stall_last, 5);

        // 2: STMDB R13!,{R4,R14}, R13=0x200
        run_seq(32'hE92D_4010, 32'h0000_0200);
        check("t2_mem_cnt", q_mem_addr.size(), 2);
        exp_mem("t2_m0", 0, 32'h1F8, 32'h4444_4444, 1'b1);
        exp_mem("t2_m1", 1, 32'h1FC, 32'hEEEE_0000, 1'b1);
        check("t2_rf_cnt", q_rf_waddr.size(), 1);
        exp_rf("t2_wb", 0, 4'd13, 32'h1F8);
        check("t2_done_cyc",  done_cyc,  5);
        check("t2_stall_cnt", stall_cnt, 5);

        // 3: LDMIB R2,{R0}, R2=0x40, no writeback
        run_seq(32'hE992_0001, 32'h0000_0040);
        check("t3_mem_cnt", q_mem_addr.size(), 1);
        exp_mem("t3_m0", 0, 32'h44, 32'd0, 1'b0);
        check("t3_rf_cnt", q_rf_waddr.size(), 1);
        exp_rf("t3_r0", 0, 4'd0, 32'h1234_5678);
        check("t3_done_cyc", done_cyc, 3);

        // 4a: LDMDA R3,{R0,R7}, R3=0x20
        run_seq(32'hE813_0081, 32'h0000_0020);
        check("t4_mem_cnt", q_mem_addr.size(), 2);
        exp_mem("t4_m0", 0, 32'h1C, 32'd0, 1'b0);
        exp_mem("t4_m1", 1, 32'h20, 32'd0, 1'b0);
        check("t4_rf_cnt", q_rf_waddr.size(), 2);
        exp_rf("t4_r0", 0, 4'd0, 32'h1C1C);
        exp_rf("t4_r7", 1, 4'd7, 32'h2020);
        check("t4_done_cyc", done_cyc, 4);

        // 4b: empty list with W=1
        run_seq(32'hE8B4_0000, 32'h0000_0300);
        check("t4e_mem_cnt",   q_mem_addr.size(), 0);
        check("t4e_rf_cnt",    q_rf_waddr.size(), 0);
        check("t4e_done_cyc",  done_cyc,          2);
        check("t4e_stall_cnt", stall_cnt,         2);

        // 5: LDMIA R1!,{R1,R5}, base in list: loaded value wins
        run_seq(32'hE8B1_0022, 32'h0000_0080);
        check("t5_mem_cnt", q_mem_addr.size(), 2);
        exp_mem("t5_m0", 0, 32'h80, 32'd0, 1'b0);
        exp_mem("t5_m1", 1, 32'h84, 32'd0, 1'b0);
        check("t5_rf_cnt", q_rf_waddr.size(), 2);
        exp_rf("t5_r1", 0, 4'd1, 32'h8080_0001);
        exp_rf("t5_r5", 1, 4'd5, 32'h8484_0005);
        check("t5_done_cyc", done_cyc, 4);

        // 6: reset during XFER of STMIA R6!,{R8-R11}, then rerun
        clear_logs();
        @(posedge clk); #1;
        instr    = 32'hE8A6_0F00;
        base_val = 32'h0000_0300;
        start    = 1'b1;
        mon      = 1'b1;
        @(posedge clk); #1;          // cycle 1: CALC
        start = 1'b0;
        @(posedge clk); #1;          // cycle 2: XFER
        @(posedge clk); #1;          // cycle 3: XFER, reset seen at next edge
        reset = 1'b0;
        @(posedge clk);              // cycle 4: IDLE
        @(negedge clk);
        check("t6_rst_busy",      32'(busy),     32'd0);
        check("t6_rst_stall",     32'(stall),    32'd0);
        check("t6_rst_mem_en",    32'(mem_en),   32'd0);
        check("t6_rst_mem_addr",  mem_addr,      32'd0);
        check("t6_rst_mem_wdata", mem_wdata,     32'd0);
        check("t6_rst_rf_we",     32'(rf_we),    32'd0);
        check("t6_rst_rf_raddr",  32'(rf_raddr), 32'd0);
        check("t6_rst_done",      32'(done),     32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        mon = 1'b0;
        check("t6_abort_mem_cnt", q_mem_addr.size(), 2);
        exp_mem("t6_a0", 0, 32'h300, 32'h0808_0808, 1'b1);
        exp_mem("t6_a1", 1, 32'h304, 32'h0909_0909, 1'b1);
        check("t6_abort_rf_cnt", q_rf_waddr.size(), 0);
        check("t6_abort_done",   done_cyc,          32'hFFFF_FFFF);

        run_seq(32'hE8A6_0F00, 32'h0000_0300);
        check("t6_mem_cnt", q_mem_addr.size(), 4);
        exp_mem("t6_m0", 0, 32'h300, 32'h0808_0808, 1'b1);
        exp_mem("t6_m1", 1, 32'h304, 32'h0909_0909, 1'b1);
        exp_mem("t6_m2", 2, 32'h308, 32'h0A0A_0A0A, 1'b1);
        exp_mem("t6_m3", 3, 32'h30C, 32'h0B0B_0B0B, 1'b1);
        check("t6_rf_cnt", q_rf_waddr.size(), 1);
        exp_rf("t6_wb", 0, 4'd6, 32'h310);
        check("t6_done_cyc",  done_cyc,  7);
        check("t6_stall_cnt", stall_cnt, 7);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
